// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: access FSM states,
// writeback control bundle and the alignment helper.
package mem_pkg;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;
    // Wide enough for the largest supported MAX_WAIT (255).
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        StIdle,
        StWait
    } mem_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, pc_src: 1'b0};

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake control: request generation, wait counting with timeout,
// and the stall / fault / transfer-done strobes for the memory stage.
module mem_access_fsm
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic memop,
    input  logic aligned,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic fault,
    output logic done
);

    localparam logic [CNT_W-1:0] WaitLimit = CNT_W'(MAX_WAIT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;

    always_comb begin
        mem_req = memop & aligned;
        timeout = (state_q == StWait) && (cnt_q == WaitLimit);
        // An ack in the timeout cycle still completes the transfer.
        stall   = mem_req & ~mem_ack & ~timeout;
        fault   = (memop & ~aligned) | (timeout & ~mem_ack);
        done    = mem_req & mem_ack;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // The unacked first cycle already counts as one wait cycle.
                if (stall) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWait: begin
                if (mem_ack || timeout || !mem_req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != WaitLimit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the pipelined core: E->M and M->W pipeline registers around a
// variable-latency request/acknowledge data-memory port.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              PCSrcE,
    input  logic [3:0]        RdE,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              MemStall,
    output logic              MemFault,
    output logic              RegWriteM,
    output logic [3:0]        RdM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              PCSrcW,
    output logic [3:0]        RdW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW
);

    logic              reg_write_m_q, mem_to_reg_m_q, mem_write_m_q, pc_src_m_q;
    logic [3:0]        rd_m_q;
    logic [DATA_W-1:0] alu_m_q, write_data_m_q;

    wb_ctrl_t          wb_q, wb_d;
    logic [3:0]        rd_w_q;
    logic [DATA_W-1:0] alu_w_q, read_data_w_q;

    logic memop, aligned, stall, fault, done;

    assign memop   = mem_to_reg_m_q | mem_write_m_q;
    assign aligned = is_aligned(alu_m_q[1:0]);

    mem_access_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_access_fsm (
        .clk     (clk),
        .reset   (reset),
        .memop   (memop),
        .aligned (aligned),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .stall   (stall),
        .fault   (fault),
        .done    (done)
    );

    // M register: holds while the access is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            pc_src_m_q     <= 1'b0;
            rd_m_q         <= '0;
            alu_m_q        <= '0;
            write_data_m_q <= '0;
        end else if (!stall) begin
            reg_write_m_q  <= RegWriteE;
            mem_to_reg_m_q <= MemtoRegE;
            mem_write_m_q  <= MemWriteE;
            pc_src_m_q     <= PCSrcE;
            rd_m_q         <= RdE;
            alu_m_q        <= ALUResultE;
            write_data_m_q <= WriteDataE;
        end
    end

    // Stalled or faulted ops leave no architectural effect in W.
    always_comb begin
        wb_d = '{reg_write: reg_write_m_q, mem_to_reg: mem_to_reg_m_q, pc_src: pc_src_m_q};
        if (stall || fault) begin
            wb_d = WB_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q          <= WB_BUBBLE;
            rd_w_q        <= '0;
            alu_w_q       <= '0;
            read_data_w_q <= '0;
        end else begin
            wb_q    <= wb_d;
            rd_w_q  <= rd_m_q;
            alu_w_q <= alu_m_q;
            if (done && mem_to_reg_m_q) begin
                read_data_w_q <= mem_rdata;
            end
        end
    end

    assign mem_we     = mem_write_m_q;
    assign mem_addr   = alu_m_q;
    assign mem_wdata  = write_data_m_q;
    assign MemStall   = stall;
    assign MemFault   = fault;
    assign RegWriteM  = reg_write_m_q;
    assign RdM        = rd_m_q;
    assign ALUResultM = alu_m_q;
    assign RegWriteW  = wb_q.reg_write;
    assign MemtoRegW  = wb_q.mem_to_reg;
    assign PCSrcW     = wb_q.pc_src;
    assign RdW        = rd_w_q;
    assign ReadDataW  = read_data_w_q;
    assign ALUOutW    = alu_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a cycle-level behavioural model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_mem_stage;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemtoRegE, MemWriteE, PCSrcE;
    logic [3:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        MemStall, MemFault, RegWriteM;
    logic [3:0]  RdM;
    logic [31:0] ALUResultM;
    logic        RegWriteW, MemtoRegW, PCSrcW;
    logic [3:0]  RdW;
    logic [31:0] ReadDataW, ALUOutW;

    int checks   = 0;
    int failures = 0;

    mem_stage #(
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteE  (RegWriteE),
        .MemtoRegE  (MemtoRegE),
        .MemWriteE  (MemWriteE),
        .PCSrcE     (PCSrcE),
        .RdE        (RdE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .MemStall   (MemStall),
        .MemFault   (MemFault),
        .RegWriteM  (RegWriteM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .PCSrcW     (PCSrcW),
        .RdW        (RdW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Instruction sitting in M, how many cycles it has stalled, and the W contents.
    logic        model_on = 1'b0;
    logic        mm_rw, mm_mtr, mm_mw, mm_pcs;
    logic [3:0]  mm_rd;
    logic [31:0] mm_alu, mm_wd;
    int          mm_waited;
    logic        mw_rw, mw_mtr, mw_pcs, mw_valid;
    logic [3:0]  mw_rd;
    logic [31:0] mw_alu, mw_rdata;

    logic        nx_rw, nx_mtr, nx_mw, nx_pcs;
    logic [3:0]  nx_rd;
    logic [31:0] nx_alu, nx_wd;
    int          nx_waited;
    logic        nw_rw, nw_mtr, nw_pcs, nw_valid;
    logic [3:0]  nw_rd;
    logic [31:0] nw_alu, nw_rdata;

    always @(negedge clk) begin
        if (model_on) begin
            bit memop, aligned, req, timed_out, stall, fault;
            memop     = mm_mtr || mm_mw;
            aligned   = (mm_alu % 4) == 0;
            req       = memop && aligned;
            timed_out = req && (mm_waited >= int'(MAX_WAIT));
            stall     = req && !mem_ack && !timed_out;
            fault     = (memop && !aligned) || (timed_out && !mem_ack);

            check("model_mem_req", 32'(mem_req), 32'(req));
            check("model_stall", 32'(MemStall), 32'(stall));
            check("model_fault", 32'(MemFault), 32'(fault));
            check("model_regwrite_m", 32'(RegWriteM), 32'(mm_rw));
            check("model_rd_m", 32'(RdM), 32'(mm_rd));
            check("model_alu_m", ALUResultM, mm_alu);
            check("model_w_ctrl", {29'd0, RegWriteW, MemtoRegW, PCSrcW},
                  {29'd0, mw_rw, mw_mtr, mw_pcs});
            if (mw_valid) begin
                check("model_rd_w", 32'(RdW), 32'(mw_rd));
                check("model_alu_w", ALUOutW, mw_alu);
            end
            if (mw_valid && mw_mtr) check("model_rdata_w", ReadDataW, mw_rdata);
            if (req) begin
                check("model_addr", mem_addr, mm_alu);
                check("model_wdata", mem_wdata, mm_wd);
                check("model_we", 32'(mem_we), 32'(mm_mw));
            end

            nw_rdata = mw_rdata;
            if (stall) begin
                {nx_rw, nx_mtr, nx_mw, nx_pcs} = {mm_rw, mm_mtr, mm_mw, mm_pcs};
                nx_rd = mm_rd; nx_alu = mm_alu; nx_wd = mm_wd;
                nx_waited = mm_waited + 1;
                {nw_rw, nw_mtr, nw_pcs, nw_valid} = 4'b0000;
            end else begin
                {nx_rw, nx_mtr, nx_mw, nx_pcs} = {RegWriteE, MemtoRegE, MemWriteE, PCSrcE};
                nx_rd = RdE; nx_alu = ALUResultE; nx_wd = WriteDataE;
                nx_waited = 0;
                if (fault) {nw_rw, nw_mtr, nw_pcs, nw_valid} = 4'b0000;
                else {nw_rw, nw_mtr, nw_pcs, nw_valid} = {mm_rw, mm_mtr, mm_pcs, 1'b1};
                if (req && mem_ack && mm_mtr) nw_rdata = mem_rdata;
            end
            nw_rd  = mm_rd;
            nw_alu = mm_alu;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            model_on <= 1'b1;
            {mm_rw, mm_mtr, mm_mw, mm_pcs} <= 4'b0000;
            mm_rd <= '0; mm_alu <= '0; mm_wd <= '0; mm_waited <= 0;
            {mw_rw, mw_mtr, mw_pcs, mw_valid} <= 4'b0000;
            mw_rd <= '0; mw_alu <= '0; mw_rdata <= '0;
        end else if (model_on) begin
            {mm_rw, mm_mtr, mm_mw, mm_pcs} <= {nx_rw, nx_mtr, nx_mw, nx_pcs};
            mm_rd <= nx_rd; mm_alu <= nx_alu; mm_wd <= nx_wd; mm_waited <= nx_waited;
            {mw_rw, mw_mtr, mw_pcs, mw_valid} <= {nw_rw, nw_mtr, nw_pcs, nw_valid};
            mw_rd <= nw_rd; mw_alu <= nw_alu; mw_rdata <= nw_rdata;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_e(input logic rw, input logic mtr, input logic mw, input logic pcs,
                           input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        {RegWriteE, MemtoRegE, MemWriteE, PCSrcE} = {rw, mtr, mw, pcs};
        RdE = rd; ALUResultE = alu; WriteDataE = wd;
    endtask

    task automatic nop();
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_stall"}, 32'(MemStall), 32'd0);
        check({tag, "_fault"}, 32'(MemFault), 32'd0);
        check({tag, "_m"}, {27'd0, RegWriteM, RdM}, 32'd0);
        check({tag, "_alu_m"}, ALUResultM, 32'd0);
        check({tag, "_w_ctrl"}, {29'd0, RegWriteW, MemtoRegW, PCSrcW}, 32'd0);
        check({tag, "_rd_w"}, 32'(RdW), 32'd0);
        check({tag, "_alu_w"}, ALUOutW, 32'd0);
        check({tag, "_rdata_w"}, ReadDataW, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int req_n, stall_n, we_n, fault_at;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
        drive_e(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h104, 32'h77);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; nop();
        @(negedge clk);
        check_all_zero("reset");

        // Plain ALU op passes through with no request.
        next_cycle(); drive_e(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 32'h10, 32'd0);
        next_cycle(); nop();
        @(negedge clk);
        check("alu_rd_m", 32'(RdM), 32'd3);
        check("alu_result_m", ALUResultM, 32'h10);
        check("alu_no_req", 32'(mem_req), 32'd0);
        next_cycle();
        @(negedge clk);
        check("alu_rd_w", 32'(RdW), 32'd3);
        check("alu_out_w", ALUOutW, 32'h10);
        check("alu_regwrite_w", 32'(RegWriteW), 32'd1);

        // Zero-wait load.
        next_cycle(); drive_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h100, 32'd0);
        next_cycle(); nop(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ld0_req", 32'(mem_req), 32'd1);
        check("ld0_stall", 32'(MemStall), 32'd0);
        check("ld0_addr", mem_addr, 32'h100);
        next_cycle(); mem_ack = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        check("ld0_rdata_w", ReadDataW, 32'hDEADBEEF);
        check("ld0_memtoreg_w", 32'(MemtoRegW), 32'd1);

        // Store acked after three wait cycles; an ALU op waits in E.
        next_cycle(); drive_e(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h200, 32'h55);
        next_cycle(); drive_e(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 32'h44, 32'd0);
        req_n = 0; stall_n = 0; we_n = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            @(negedge clk);
            req_n += int'(mem_req); stall_n += int'(MemStall); we_n += int'(mem_we);
            check("st_addr_stable", mem_addr, 32'h200);
            check("st_wdata_stable", mem_wdata, 32'h55);
            next_cycle();
        end
        mem_ack = 1'b0; nop();
        check("st_req_cycles", 32'(req_n), 32'd4);
        check("st_we_cycles", 32'(we_n), 32'd4);
        check("st_stall_cycles", 32'(stall_n), 32'd3);
        @(negedge clk);
        check("st_next_rd_m", 32'(RdM), 32'd7);
        check("st_next_no_req", 32'(mem_req), 32'd0);

        // Misaligned load faults without a request.
        next_cycle(); drive_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h103, 32'd0);
        next_cycle(); nop();
        @(negedge clk);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_fault", 32'(MemFault), 32'd1);
        check("mis_stall", 32'(MemStall), 32'd0);
        next_cycle();
        @(negedge clk);
        check("mis_fault_pulse", 32'(MemFault), 32'd0);
        check("mis_w_bubble", {29'd0, RegWriteW, MemtoRegW, PCSrcW}, 32'd0);

        // Load never acked: times out.
        next_cycle(); drive_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h300, 32'd0);
        next_cycle(); nop();
        stall_n = 0; fault_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            stall_n += int'(MemStall);
            if (MemFault) begin
                fault_at = i;
                break;
            end
            next_cycle();
        end
        check("to_stall_cycles", 32'(stall_n), 32'd15);
        check("to_fault_cycle", 32'(fault_at), 32'd15);
        next_cycle();
        @(negedge clk);
        check("to_after_req", 32'(mem_req), 32'd0);
        check("to_after_fault", 32'(MemFault), 32'd0);
        check("to_after_stall", 32'(MemStall), 32'd0);
        check("to_w_bubble", {29'd0, RegWriteW, MemtoRegW, PCSrcW}, 32'd0);

        // Back-to-back zero-wait loads.
        next_cycle(); drive_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 32'h500, 32'd0);
        next_cycle(); drive_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h504, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1111;
        next_cycle(); nop(); mem_rdata = 32'h2222;
        @(negedge clk);
        check("b2b_req", 32'(mem_req), 32'd1);
        check("b2b_addr", mem_addr, 32'h504);
        check("b2b_first_rdata", ReadDataW, 32'h1111);
        check("b2b_first_rd", 32'(RdW), 32'd8);
        next_cycle(); mem_ack = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        check("b2b_second_rdata", ReadDataW, 32'h2222);
        check("b2b_second_rd", 32'(RdW), 32'd9);

        // Reset in the second wait cycle; a late ack is ignored.
        next_cycle(); drive_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h400, 32'd0);
        next_cycle(); nop();
        next_cycle();
        next_cycle(); reset = 1'b1;
        @(negedge clk);
        check("rst_mid_stall_before", 32'(MemStall), 32'd1);
        next_cycle(); reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        check_all_zero("rst_mid");
        next_cycle(); mem_ack = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        check("rst_late_ack_rdata", ReadDataW, 32'd0);
        check("rst_late_ack_ctrl", {29'd0, RegWriteW, MemtoRegW, PCSrcW}, 32'd0);

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
